// File: rtl/spi_host.sv
// SPI mode-0 initiator: MSB first, byte-level valid/ready transmit, one-cycle receive strobe.
// All SPI timing is counted in mclk cycles; spi_clk, spi_cs and spi_mosi are registered.
module spi_host #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT    = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_DESELECT = 2'd3;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] IDLE_LAST = 8'(CS_IDLE - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic [6:0] tx_sr;
  logic [6:0] rx_sr;
  logic       last_q;
  logic       accept;

  // The strobe cycle is excluded so a new byte never starts on the edge that completes one.
  assign tx_ready = (state == ST_IDLE) || ((state == ST_HOLD) && !rx_valid);
  assign busy     = (state != ST_IDLE);
  assign accept   = tx_valid && tx_ready;

  // NOTE: every register here, including the shift registers, is reset so a reset mid-byte
  // leaves no trace of the partial transfer; all state updates use non-blocking assignments.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      bit_idx  <= 3'd0;
      tx_sr    <= 7'd0;
      rx_sr    <= 7'd0;
      last_q   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            tx_sr    <= tx_data[6:0];
            last_q   <= tx_last;
            spi_cs   <= 1'b0;
            spi_mosi <= tx_data[7];
            bit_idx  <= 3'd7;
            cnt      <= 8'd0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= 8'd0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              // End of the high phase: sample, then either move on or close the byte.
              spi_clk <= 1'b0;
              rx_sr   <= {rx_sr[5:0], spi_miso};
              if (bit_idx == 3'd0) begin
                rx_valid <= 1'b1;
                rx_data  <= {rx_sr, spi_miso};
                if (last_q) begin
                  state    <= ST_DESELECT;
                  spi_cs   <= 1'b1;
                  spi_mosi <= 1'b1;
                end else begin
                  state <= ST_HOLD;
                end
              end else begin
                bit_idx  <= bit_idx - 3'd1;
                spi_mosi <= tx_sr[6];
                tx_sr    <= {tx_sr[5:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DESELECT: begin
          if (cnt == IDLE_LAST) begin
            cnt   <= 8'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host: loopback and a behavioural SPI device, edge timing
// predicted from the accept cycle T and the divider.
module tb_spi_host;

  localparam int D   = 4;
  localparam int CSI = 2;
  localparam int BUDGET = 3000;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, rx_valid, busy, spi_cs, spi_clk, spi_mosi;
  logic [7:0] rx_data;
  logic       spi_miso;
  logic       loopback = 1'b1;
  logic       dev_miso = 1'b1;

  int checks = 0;
  int passes = 0;

  spi_host #(.CLK_DIV(D), .CS_IDLE(CSI)) dut (
    .mclk(mclk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  assign spi_miso = loopback ? spi_mosi : dev_miso;

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // Bus monitor: event times are posedge indices, sampled 1 time unit after the edge.
  int         rises[$];
  int         cs_fall[$];
  int         cs_rise[$];
  int         rx_t[$];
  logic [7:0] rx_d[$];
  int         clk_while_cs = 0;
  int         rx_long = 0;
  logic       p_clk = 1'b0, p_cs = 1'b1, p_rxv = 1'b0;

  always @(posedge mclk) begin
    #1;
    if (spi_clk && !p_clk) rises.push_back(cyc);
    if ((spi_clk !== p_clk) && spi_cs && p_cs) clk_while_cs++;
    if (!spi_cs && p_cs) cs_fall.push_back(cyc);
    if (spi_cs && !p_cs) cs_rise.push_back(cyc);
    if (rx_valid) begin
      rx_t.push_back(cyc);
      rx_d.push_back(rx_data);
      if (p_rxv) rx_long++;
    end
    p_clk = spi_clk;
    p_cs  = spi_cs;
    p_rxv = rx_valid;
  end

  // Behavioural SPI device: shifts replies out on falling spi_clk, captures MOSI on rising.
  logic [7:0] dev_resp[$];
  logic [7:0] dev_rx[$];
  logic [7:0] dev_cur = 8'hFF;
  logic [7:0] dev_sr = 8'h00;
  int         dev_bit = 7;
  int         dev_n = 0;
  logic       dev_active = 1'b0;

  always @(spi_cs or spi_clk) begin
    if (spi_cs !== 1'b0) begin
      dev_active = 1'b0;
      dev_n      = 0;
      dev_miso   = 1'b1;
    end else if (!dev_active) begin
      dev_active = 1'b1;
      dev_cur    = (dev_resp.size() > 0) ? dev_resp.pop_front() : 8'hFF;
      dev_bit    = 7;
      dev_n      = 0;
      dev_miso   = dev_cur[7];
    end else if (spi_clk) begin
      dev_sr = {dev_sr[6:0], spi_mosi};
      dev_n++;
      if (dev_n == 8) begin
        dev_rx.push_back(dev_sr);
        dev_n = 0;
      end
    end else begin
      if (dev_bit == 0) begin
        dev_cur = (dev_resp.size() > 0) ? dev_resp.pop_front() : 8'hFF;
        dev_bit = 7;
      end else begin
        dev_bit--;
      end
      dev_miso = dev_cur[dev_bit];
    end
  end

  // Reference timing: k-th rising spi_clk edge of a byte accepted at edge t.
  function automatic int rise_at(input int t, input int k);
    return t + (2 * k + 1) * D;
  endfunction

  task automatic clear_mon();
    rises.delete(); cs_fall.delete(); cs_rise.delete(); rx_t.delete(); rx_d.delete();
    dev_rx.delete();
  endtask

  // Called on a falling mclk edge; returns the accept edge index or -1 on timeout.
  task automatic send(input logic [7:0] d, input logic l, output int t);
    t = -1;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    for (int i = 0; i < BUDGET; i++) begin
      if (tx_ready) begin
        @(posedge mclk); #1;
        t = cyc;
        break;
      end
      @(negedge mclk);
    end
    @(negedge mclk);
    tx_valid = 1'b0; tx_data = 8'($urandom); tx_last = 1'($urandom);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (rx_d.size() >= n) begin ok = 1'b1; break; end
      @(negedge mclk);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks += 6;
    if (spi_cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", spi_cs); else passes++;
    if (spi_clk !== 1'b0) $display("FAIL reset_clk: got %b want 0", spi_clk); else passes++;
    if (spi_mosi !== 1'b1) $display("FAIL reset_mosi: got %b want 1", spi_mosi); else passes++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rxv: got %b want 0", rx_valid); else passes++;
    if (rx_data !== 8'h00) $display("FAIL reset_rxd: got %h want 00", rx_data); else passes++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    checks += 2;
    if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", tx_ready); else passes++;
    if (busy !== 1'b0) $display("FAIL reset_busy_rel: got %b want 0", busy); else passes++;
  endtask

  task automatic test_single(input logic [7:0] d);
    int t, bad, rdy_t;
    bit ok;
    loopback = 1'b1;
    clear_mon();
    send(d, 1'b1, t);
    wait_rx(1, ok);
    checks += 7;
    if (!ok || t < 0) $display("FAIL single_timeout: accept %0d rx_seen %0d want accept and rx", t, ok);
    else passes++;
    if (rx_d[0] !== d) $display("FAIL single_rxd: got %h want %h", rx_d[0], d); else passes++;
    if (rx_t[0] != t + 16 * D) $display("FAIL single_rxt: got %0d want %0d", rx_t[0], t + 16 * D);
    else passes++;
    if (rises.size() != 8) $display("FAIL single_nrise: got %0d want 8", rises.size()); else passes++;
    bad = 0;
    for (int k = 0; k < 8; k++) if (rises[k] != rise_at(t, k)) bad++;
    if (bad != 0) $display("FAIL single_rise_time: got %0d misplaced edges want 0", bad); else passes++;
    if (cs_fall[0] != t) $display("FAIL single_cs_fall: got %0d want %0d", cs_fall[0], t); else passes++;
    if (cs_rise[0] != t + 16 * D) $display("FAIL single_cs_rise: got %0d want %0d", cs_rise[0], t + 16 * D);
    else passes++;
    rdy_t = -1;
    for (int i = 0; i < BUDGET; i++) begin
      if (tx_ready) begin rdy_t = cyc; break; end
      @(negedge mclk);
    end
    checks++;
    if (rdy_t != t + 16 * D + CSI) $display("FAIL single_ready: got %0d want %0d", rdy_t, t + 16 * D + CSI);
    else passes++;
  endtask

  task automatic test_burst();
    int t1, t2, bad;
    bit ok;
    loopback = 1'b0;
    dev_resp.delete();
    dev_resp.push_back(8'hEF);
    dev_resp.push_back(8'h40);
    clear_mon();
    send(8'h9F, 1'b0, t1);
    send(8'h00, 1'b1, t2);
    wait_rx(2, ok);
    @(negedge mclk);
    checks += 8;
    if (!ok) $display("FAIL burst_timeout: got %0d bytes want 2", rx_d.size()); else passes++;
    if (rx_d[0] !== 8'hEF) $display("FAIL burst_rx0: got %h want ef", rx_d[0]); else passes++;
    if (rx_d[1] !== 8'h40) $display("FAIL burst_rx1: got %h want 40", rx_d[1]); else passes++;
    if (t2 != t1 + 16 * D + 2) $display("FAIL burst_gap: got %0d want %0d", t2, t1 + 16 * D + 2);
    else passes++;
    if (rises.size() != 16) $display("FAIL burst_nrise: got %0d want 16", rises.size()); else passes++;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (rises[k] != rise_at(t1, k)) bad++;
      if (rises[k + 8] != rise_at(t2, k)) bad++;
    end
    if (bad != 0) $display("FAIL burst_rise_time: got %0d misplaced edges want 0", bad); else passes++;
    if (cs_fall.size() != 1 || cs_rise.size() != 1)
      $display("FAIL burst_cs_cont: got %0d falls %0d rises want 1 and 1", cs_fall.size(), cs_rise.size());
    else passes++;
    if (dev_rx.size() != 2 || dev_rx[0] !== 8'h9F || dev_rx[1] !== 8'h00)
      $display("FAIL burst_dev_rx: got %0d bytes %h %h want 9f 00", dev_rx.size(), dev_rx[0], dev_rx[1]);
    else passes++;
  endtask

  task automatic test_hold_stall();
    int t, t2, bad;
    bit ok;
    loopback = 1'b1;
    clear_mon();
    send(8'h06, 1'b0, t);
    wait_rx(1, ok);
    repeat (2) @(negedge mclk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(spi_cs === 1'b0 && spi_clk === 1'b0 && tx_ready === 1'b1 && busy === 1'b1)) bad++;
      @(negedge mclk);
    end
    checks += 3;
    if (!ok) $display("FAIL hold_timeout: got %0d bytes want 1", rx_d.size()); else passes++;
    if (bad != 0) $display("FAIL hold_state: got %0d bad cycles want 0", bad); else passes++;
    if (rises.size() != 8) $display("FAIL hold_edges: got %0d rises want 8", rises.size()); else passes++;
    send(8'h01, 1'b1, t2);
    wait_rx(2, ok);
    checks += 4;
    if (rx_d[0] !== 8'h06) $display("FAIL hold_rx0: got %h want 06", rx_d[0]); else passes++;
    if (rx_d[1] !== 8'h01) $display("FAIL hold_rx1: got %h want 01", rx_d[1]); else passes++;
    if (rx_t[1] != t2 + 16 * D) $display("FAIL hold_rxt: got %0d want %0d", rx_t[1], t2 + 16 * D);
    else passes++;
    if (cs_fall.size() != 1) $display("FAIL hold_cs_once: got %0d falls want 1", cs_fall.size()); else passes++;
  endtask

  task automatic test_reset_mid_shift();
    int t, t2, bad;
    bit ok;
    loopback = 1'b1;
    clear_mon();
    send(8'hF0, 1'b1, t);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (rises.size() >= 3) begin ok = 1'b1; break; end
      @(negedge mclk);
    end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (!ok) $display("FAIL midrst_timeout: got %0d rises want 3", rises.size()); else passes++;
    if (spi_cs !== 1'b1) $display("FAIL midrst_cs: got %b want 1", spi_cs); else passes++;
    if (spi_clk !== 1'b0) $display("FAIL midrst_clk: got %b want 0", spi_clk); else passes++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
    @(negedge mclk);
    reset = 1'b0;
    repeat (20 * D) @(negedge mclk);
    checks++;
    if (rx_d.size() != 0) $display("FAIL midrst_no_rx: got %0d strobes want 0", rx_d.size()); else passes++;
    clear_mon();
    send(8'h3C, 1'b1, t2);
    wait_rx(1, ok);
    checks += 3;
    if (rx_d[0] !== 8'h3C) $display("FAIL midrst_rxd: got %h want 3c", rx_d[0]); else passes++;
    if (rx_t[0] != t2 + 16 * D) $display("FAIL midrst_rxt: got %0d want %0d", rx_t[0], t2 + 16 * D);
    else passes++;
    bad = 0;
    for (int k = 0; k < 8; k++) if (rises[k] != rise_at(t2, k)) bad++;
    if (bad != 0 || rises.size() != 8)
      $display("FAIL midrst_rise_time: got %0d misplaced of %0d want 0 of 8", bad, rises.size());
    else passes++;
    repeat (CSI + 2) @(negedge mclk);
  endtask

  task automatic test_integration();
    logic [7:0] cmd [3];
    logic [7:0] resp[3];
    int t, bad;
    bit ok;
    cmd[0] = 8'h03; cmd[1] = 8'h12; cmd[2] = 8'h34;
    loopback = 1'b0;
    dev_resp.delete();
    for (int i = 0; i < 3; i++) begin
      resp[i] = 8'($urandom);
      dev_resp.push_back(resp[i]);
    end
    clear_mon();
    for (int i = 0; i < 3; i++) send(cmd[i], (i == 2), t);
    wait_rx(3, ok);
    @(negedge mclk);
    bad = 0;
    for (int i = 0; i < 3; i++) if (dev_rx[i] !== cmd[i] || rx_d[i] !== resp[i]) bad++;
    checks += 4;
    if (!ok) $display("FAIL integ_timeout: got %0d bytes want 3", rx_d.size()); else passes++;
    if (dev_rx.size() != 3) $display("FAIL integ_dev_count: got %0d want 3", dev_rx.size()); else passes++;
    if (bad != 0) $display("FAIL integ_data: got %0d wrong bytes want 0", bad); else passes++;
    if (cs_fall.size() != 1 || cs_rise.size() != 1)
      $display("FAIL integ_cs_cont: got %0d falls %0d rises want 1 and 1", cs_fall.size(), cs_rise.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_single(8'($urandom));
    test_burst();
    test_hold_stall();
    test_reset_mid_shift();
    test_integration();
    checks += 2;
    if (clk_while_cs != 0) $display("FAIL clk_idle_cs: got %0d toggles want 0", clk_while_cs); else passes++;
    if (rx_long != 0) $display("FAIL rx_pulse_width: got %0d long pulses want 0", rx_long); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
